// File: rtl/banco_reg_pkg.sv
// Shared types and constants for the banco_reg datapath storage front-end.
package banco_reg_pkg;

  localparam int WIDTH  = 16;
  localparam int NREGS  = 8;
  localparam int IMM_W  = 10;
  localparam int ADDR_W = $clog2(NREGS);

  typedef logic [WIDTH-1:0]  word_t;
  typedef logic [ADDR_W-1:0] regIdx_t;

  typedef enum logic [2:0] {
    ADD = 3'd0,
    SUB = 3'd1,
    NAN = 3'd2,
    HLT = 3'd3,
    OUT = 3'd4,
    LDI = 3'd5,
    BNE = 3'd6,
    REP = 3'd7
  } opcode_t;

  // Instruction word layout: OP=[15:13], RA=[12:10], RB=[9:7], remainder below.
  typedef struct packed {
    opcode_t    op;
    regIdx_t    ra;
    regIdx_t    rb;
    logic [6:0] rest;
  } instr_t;

endpackage

// File: rtl/banco_reg_phase_counter.sv
// 2-bit instruction-phase counter: wraps 3 -> 0, synchronous clear and reset.
module banco_reg_phase_counter (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       clear,
  output logic [1:0] count
);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      count <= 2'd0;
    end else if (clear) begin
      count <= 2'd0;
    end else begin
      count <= count + 2'd1;
    end
  end

endmodule

// File: rtl/banco_reg.sv
// Register file, phase counter and immediate sign-extender for the multi-cycle CPU.
// Build option BANCO_REG_R0_ZERO_EN hardwires register 0 to zero.
module banco_reg
  import banco_reg_pkg::*;
(
  input  logic       clock,
  input  logic       reset_n,
  input  logic       w,
  input  regIdx_t    key,
  input  word_t      in,
  output word_t      out,
  input  logic       cnt_clear,
  output logic [1:0] cnt_out,
  input  word_t      ext_in,
  output word_t      ext_out
);

  word_t regs [NREGS];
  logic  writeEn;

`ifdef BANCO_REG_R0_ZERO_EN
  assign writeEn = w && (key != '0);
  assign out     = (key == '0) ? '0 : regs[key];
`else
  assign writeEn = w;
  assign out     = regs[key];
`endif

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (writeEn) begin
      regs[key] <= in;
    end
  end

  banco_reg_phase_counter phaseCounter (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (cnt_clear),
    .count   (cnt_out)
  );

  // Opcode and Ra fields above the immediate take no part in the extension.
  logic unusedExtHi;
  assign unusedExtHi = ^ext_in[WIDTH-1:IMM_W];

  assign ext_out = {{(WIDTH-IMM_W){ext_in[IMM_W-1]}}, ext_in[IMM_W-1:0]};

endmodule

// File: tb/tb_banco_reg.sv
// Directed self-checking bench for banco_reg: register file, phase counter, extender.
module tb_banco_reg;
  import banco_reg_pkg::*;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       w;
  regIdx_t    key;
  word_t      in;
  word_t      out;
  logic       cnt_clear;
  logic [1:0] cnt_out;
  word_t      ext_in;
  word_t      ext_out;

  int passCount  = 0;
  int totalCount = 0;

  banco_reg dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .w         (w),
    .key       (key),
    .in        (in),
    .out       (out),
    .cnt_clear (cnt_clear),
    .cnt_out   (cnt_out),
    .ext_in    (ext_in),
    .ext_out   (ext_out)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick();
    totalCount++;
    if (cnt_out !== 2'd0) $display("FAIL reset_cnt: got %0d expected 0", cnt_out);
    else passCount++;
    for (int k = 0; k < 8; k++) begin
      key = regIdx_t'(k);
      #1;
      totalCount++;
      if (out !== 16'h0000) $display("FAIL reset_out[%0d]: got %h expected 0000", k, out);
      else passCount++;
    end
    reset_n = 1'b1;
  endtask

  task automatic test_write_read();
    word_t exp;
    w = 1'b1;
    for (int k = 0; k < 8; k++) begin
      key = regIdx_t'(k);
      in  = word_t'(16'h1111 * k);
      tick();
    end
    w = 1'b0;
    for (int k = 0; k < 8; k++) begin
      key = regIdx_t'(k);
      #1;
      exp = word_t'(16'h1111 * k);
      totalCount++;
      if (out !== exp) $display("FAIL read_all[%0d]: got %h expected %h", k, out, exp);
      else passCount++;
    end
    // reg0 with a nonzero value exercises the hardwired-zero option
    key = 3'd0; in = 16'h5A5A; w = 1'b1;
    tick();
    w = 1'b0;
`ifdef BANCO_REG_R0_ZERO_EN
    exp = 16'h0000;
`else
    exp = 16'h5A5A;
`endif
    totalCount++;
    if (out !== exp) $display("FAIL reg0_write: got %h expected %h", out, exp);
    else passCount++;
    key = 3'd3; in = 16'hBEEF; w = 1'b1;
    #1;
    totalCount++;
    if (out !== 16'h3333) $display("FAIL same_cycle_old: got %h expected 3333", out);
    else passCount++;
    tick();
    w = 1'b0;
    totalCount++;
    if (out !== 16'hBEEF) $display("FAIL same_cycle_new: got %h expected beef", out);
    else passCount++;
  endtask

  task automatic test_write_disable();
    w = 1'b0; in = 16'hFFFF; key = 3'd2;
    for (int i = 0; i < 3; i++) begin
      tick();
      totalCount++;
      if (out !== 16'h2222) $display("FAIL write_disable[%0d]: got %h expected 2222", i, out);
      else passCount++;
    end
  endtask

  task automatic test_counter();
    logic [1:0] expSeq [6] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2};
    reset_n = 1'b0; cnt_clear = 1'b0;
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      totalCount++;
      if (cnt_out !== expSeq[i]) $display("FAIL cnt_seq[%0d]: got %0d expected %0d", i, cnt_out, expSeq[i]);
      else passCount++;
    end
    cnt_clear = 1'b1;
    tick();
    totalCount++;
    if (cnt_out !== 2'd0) $display("FAIL cnt_clear: got %0d expected 0", cnt_out);
    else passCount++;
    tick();
    totalCount++;
    if (cnt_out !== 2'd0) $display("FAIL cnt_clear_hold: got %0d expected 0", cnt_out);
    else passCount++;
    cnt_clear = 1'b0;
    tick();
    totalCount++;
    if (cnt_out !== 2'd1) $display("FAIL cnt_after_clear: got %0d expected 1", cnt_out);
    else passCount++;
  endtask

  task automatic test_extender();
    word_t vin  [6] = '{16'hA005, 16'hA200, 16'hC1FF, 16'h03FF, 16'hA07F, 16'hA3FF};
    word_t vexp [6] = '{16'h0005, 16'hFE00, 16'h01FF, 16'hFFFF, 16'h007F, 16'hFFFF};
    for (int i = 0; i < 6; i++) begin
      ext_in = vin[i];
      #1;
      totalCount++;
      if (ext_out !== vexp[i]) $display("FAIL ext[%h]: got %h expected %h", vin[i], ext_out, vexp[i]);
      else passCount++;
    end
  endtask

  task automatic test_reset_mid();
    cnt_clear = 1'b1;
    tick();
    cnt_clear = 1'b0;
    key = 3'd5; in = 16'h00AA; w = 1'b1;
    tick();
    w = 1'b0;
    tick();
    tick();
    totalCount++;
    if (cnt_out !== 2'd3) $display("FAIL mid_pre_cnt: got %0d expected 3", cnt_out);
    else passCount++;
    totalCount++;
    if (out !== 16'h00AA) $display("FAIL mid_pre_reg5: got %h expected 00aa", out);
    else passCount++;
    reset_n = 1'b0; w = 1'b1; key = 3'd5; in = 16'h1234;
    tick();
    w = 1'b0;
    totalCount++;
    if (out !== 16'h0000) $display("FAIL mid_reg5: got %h expected 0000", out);
    else passCount++;
    totalCount++;
    if (cnt_out !== 2'd0) $display("FAIL mid_cnt: got %0d expected 0", cnt_out);
    else passCount++;
    key = 3'd3;
    #1;
    totalCount++;
    if (out !== 16'h0000) $display("FAIL mid_reg3: got %h expected 0000", out);
    else passCount++;
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0; w = 1'b0; key = '0; in = '0; cnt_clear = 1'b0; ext_in = '0;
    test_reset();
    test_write_read();
    test_write_disable();
    test_counter();
    test_extender();
    test_reset_mid();
    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
